limbus_sysid_check: RTL and testbench

Boot-time and periodic integrity checker for the Limbus system-ID slave. It acts as a single-master Avalon-MM read sequencer. After reset, or on command, it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, retries on mismatch, and publishes a sticky pass/fail status. That status gates firmware bring-up and feeds the status CSR block.

---
 rtl/limbus_sysid_check.sv | 185 ++++++++++++++++++
 tb/tb_limbus_sysid_check.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limbus_sysid_check.sv
// Limbus system-ID integrity checker.
// Reads ID and timestamp words over Avalon-MM, compares, retries, publishes status.
module limbus_sysid_check #(
   parameter logic [31:0] EXP_ID         = 32'd0,
   parameter logic [31:0] EXP_TS         = 32'd1383563533,
   parameter int          READ_LATENCY   = 0,
   parameter int          MAX_RETRY      = 3,
   parameter logic [23:0] RECHECK_CYCLES = 24'd0,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [3:0]  retry_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      LAT_ID,
      RD_TS,
      LAT_TS,
      CHECK,
      HOLD
   } state_t;

   localparam logic [1:0] LAT_M1 =
      (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

   state_t      state;
   logic        auto_pend;
   logic [1:0]  lat_cnt;
   logic [23:0] hold_cnt;
   logic [31:0] id_cap;
   logic [31:0] ts_cap;
   logic        id_bad;
   logic        ts_bad;

   // Compare the shadow captures against the build-time words
   always_comb begin
      id_bad = (id_cap != EXP_ID);
      ts_bad = (ts_cap != EXP_TS);
   end

   // Read sequencer; published status only changes on a terminal check
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         auto_pend   <= AUTO_START;
         lat_cnt     <= 2'd0;
         hold_cnt    <= 24'd0;
         id_cap      <= 32'd0;
         ts_cap      <= 32'd0;
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         valid       <= 1'b0;
         pass        <= 1'b0;
         id_mismatch <= 1'b0;
         ts_mismatch <= 1'b0;
         id_value    <= 32'd0;
         ts_value    <= 32'd0;
         retry_cnt   <= 4'd0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start || auto_pend) begin
                  auto_pend   <= 1'b0;
                  retry_cnt   <= 4'd0;
                  state       <= RD_ID;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            RD_ID: begin
               if (!avm_waitrequest) begin
                  if (READ_LATENCY == 0) begin
                     id_cap      <= avm_readdata;
                     state       <= RD_TS;
                     avm_address <= 1'b1;
                  end else begin
                     lat_cnt  <= LAT_M1;
                     state    <= LAT_ID;
                     avm_read <= 1'b0;
                  end
               end
            end
            LAT_ID: begin
               if (lat_cnt == 2'd0) begin
                  id_cap      <= avm_readdata;
                  state       <= RD_TS;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            RD_TS: begin
               if (!avm_waitrequest) begin
                  if (READ_LATENCY == 0) begin
                     ts_cap      <= avm_readdata;
                     state       <= CHECK;
                     avm_read    <= 1'b0;
                     avm_address <= 1'b0;
                  end else begin
                     lat_cnt  <= LAT_M1;
                     state    <= LAT_TS;
                     avm_read <= 1'b0;
                  end
               end
            end
            LAT_TS: begin
               if (lat_cnt == 2'd0) begin
                  ts_cap      <= avm_readdata;
                  state       <= CHECK;
                  avm_address <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            CHECK: begin
               if ((id_bad || ts_bad) && (retry_cnt < RETRY_MAX)) begin
                  retry_cnt   <= retry_cnt + 4'd1;
                  state       <= RD_ID;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
               end else begin
                  pass        <= !(id_bad || ts_bad);
                  id_mismatch <= id_bad;
                  ts_mismatch <= ts_bad;
                  id_value    <= id_cap;
                  ts_value    <= ts_cap;
                  done        <= 1'b1;
                  valid       <= 1'b1;
                  busy        <= 1'b0;
                  hold_cnt    <= RECHECK_CYCLES;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (start) begin
                  retry_cnt   <= 4'd0;
                  hold_cnt    <= 24'd0;
                  state       <= RD_ID;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  busy        <= 1'b1;
               end else if (RECHECK_CYCLES != 24'd0) begin
                  if (hold_cnt == 24'd0) begin
                     retry_cnt   <= 4'd0;
                     state       <= RD_ID;
                     avm_read    <= 1'b1;
                     avm_address <= 1'b0;
                     busy        <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt - 24'd1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               avm_read <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_limbus_sysid_check.sv
// Bench for limbus_sysid_check: two instances (zero-latency, and
// latency 2 with stalls and periodic re-check) against a sysid slave model.
module tb_limbus_sysid_check;

   localparam logic [31:0] EXP_TS = 32'd1383563533;
   localparam int          LAT_B  = 2;

   typedef struct {
      logic        ps;
      logic        idm;
      logic        tsm;
      logic [31:0] idv;
      logic [31:0] tsv;
      logic [3:0]  rc;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst_n;
   logic [1:0]  start;
   logic [1:0]  addr;
   logic [1:0]  rd;
   logic [1:0]  wt;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [1:0]  valid;
   logic [1:0]  pass;
   logic [1:0]  idm;
   logic [1:0]  tsm;
   logic [31:0] rdata [2];
   logic [31:0] idv [2];
   logic [31:0] tsv [2];
   logic [3:0]  rc [2];

   int          stall [2];
   int          scnt [2];
   int          dly [2];
   int          ts_bad [2];
   int          ts_rd [2];
   int          cyc [2];
   int          dones [2] = '{0, 0};
   logic        pend [2];
   logic [31:0] pdata [2];
   logic [31:0] id_m [2];

   exp_t        q0 [$];
   exp_t        q1 [$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        watch = 1'b0;
   logic        stalled = 1'b0;
   logic        st_addr = 1'b0;
   int          d0;
   int          d1;

   always #5 clk = ~clk;

   limbus_sysid_check u_a (
      .clock          (clk),
      .reset_n        (rst_n[0]),
      .start          (start[0]),
      .avm_address    (addr[0]),
      .avm_read       (rd[0]),
      .avm_waitrequest(wt[0]),
      .avm_readdata   (rdata[0]),
      .busy           (busy[0]),
      .done           (done[0]),
      .valid          (valid[0]),
      .pass           (pass[0]),
      .id_mismatch    (idm[0]),
      .ts_mismatch    (tsm[0]),
      .id_value       (idv[0]),
      .ts_value       (tsv[0]),
      .retry_cnt      (rc[0])
   );

   limbus_sysid_check #(
      .READ_LATENCY  (LAT_B),
      .RECHECK_CYCLES(24'd10)
   ) u_b (
      .clock          (clk),
      .reset_n        (rst_n[1]),
      .start          (start[1]),
      .avm_address    (addr[1]),
      .avm_read       (rd[1]),
      .avm_waitrequest(wt[1]),
      .avm_readdata   (rdata[1]),
      .busy           (busy[1]),
      .done           (done[1]),
      .valid          (valid[1]),
      .pass           (pass[1]),
      .id_mismatch    (idm[1]),
      .ts_mismatch    (tsm[1]),
      .id_value       (idv[1]),
      .ts_value       (tsv[1]),
      .retry_cnt      (rc[1])
   );

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : LAT_B;
   endfunction

   // Slave content: timestamp reads bad for the first ts_bad rounds
   function automatic logic [31:0] mval(input int i, input logic a);
      if (a) return (ts_rd[i] < ts_bad[i]) ? 32'h0 : EXP_TS;
      return id_m[i];
   endfunction

   function automatic exp_t mk(input logic ps, input logic im,
                               input logic tm, input logic [31:0] iv,
                               input logic [31:0] tv, input logic [3:0] r,
                               input int c);
      exp_t e;
      e.ps  = ps;
      e.idm = im;
      e.tsm = tm;
      e.idv = iv;
      e.tsv = tv;
      e.rc  = r;
      e.cyc = c;
      return e;
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic score(input int i, input exp_t e);
      string p;
      p = (i == 0) ? "a_" : "b_";
      check({p, "pass"}, 32'(pass[i]), 32'(e.ps));
      check({p, "valid"}, 32'(valid[i]), 32'd1);
      check({p, "id_mis"}, 32'(idm[i]), 32'(e.idm));
      check({p, "ts_mis"}, 32'(tsm[i]), 32'(e.tsm));
      check({p, "id_value"}, idv[i], e.idv);
      check({p, "ts_value"}, tsv[i], e.tsv);
      check({p, "retry_cnt"}, 32'(rc[i]), 32'(e.rc));
      if (e.cyc >= 0)
         check({p, "done_cycle"}, 32'(cyc[i]), 32'(e.cyc));
   endtask

   task automatic check_rst(input int i);
      string p;
      p = (i == 0) ? "a_rst_" : "b_rst_";
      check({p, "read"}, 32'(rd[i]), 0);
      check({p, "addr"}, 32'(addr[i]), 0);
      check({p, "busy"}, 32'(busy[i]), 0);
      check({p, "done"}, 32'(done[i]), 0);
      check({p, "valid"}, 32'(valid[i]), 0);
      check({p, "pass"}, 32'(pass[i]), 0);
      check({p, "id_mis"}, 32'(idm[i]), 0);
      check({p, "ts_mis"}, 32'(tsm[i]), 0);
      check({p, "id_value"}, idv[i], 0);
      check({p, "ts_value"}, tsv[i], 0);
      check({p, "retry"}, 32'(rc[i]), 0);
   endtask

   task automatic wait_drain(input int i, input int budget);
      int n;
      n = 0;
      while (qsize(i) != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check((i == 0) ? "a_drain" : "b_drain", 32'(qsize(i)), 0);
   endtask

   // Slave model: stall and read-data paths
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         logic w;
         w = rd[i] && (scnt[i] < stall[i]);
         wt[i] = w;
         rdata[i] = 32'hA5A5_0000 ^ 32'(cyc[i]);
         if (lat_of(i) == 0 && rd[i] && !w)
            rdata[i] = mval(i, addr[i]);
         else if (pend[i] && dly[i] == 0)
            rdata[i] = pdata[i];
      end
   end

   // Slave model: acceptance, latency pipe and cycle counters
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n[i]) begin
            scnt[i]  <= 0;
            pend[i]  <= 1'b0;
            dly[i]   <= 0;
            ts_rd[i] <= 0;
            cyc[i]   <= 0;
         end else begin
            cyc[i] <= cyc[i] + 1;
            if (rd[i] && wt[i]) begin
               scnt[i] <= scnt[i] + 1;
            end else if (rd[i]) begin
               scnt[i] <= 0;
               if (addr[i]) ts_rd[i] <= ts_rd[i] + 1;
               if (lat_of(i) > 0) begin
                  pend[i]  <= 1'b1;
                  dly[i]   <= lat_of(i) - 1;
                  pdata[i] <= mval(i, addr[i]);
               end
            end else if (pend[i]) begin
               if (dly[i] == 0) pend[i] <= 1'b0;
               else dly[i] <= dly[i] - 1;
            end
         end
      end
   end

   // Scoreboard pops on each done pulse; also stall and status-hold checks
   always @(negedge clk) begin
      if (rst_n[0] && done[0]) begin
         dones[0] = dones[0] + 1;
         if (q0.size() == 0) check("a_extra_done", 1, 0);
         else score(0, q0.pop_front());
      end
      if (rst_n[1] && done[1]) begin
         dones[1] = dones[1] + 1;
         if (q1.size() == 0) check("b_extra_done", 1, 0);
         else score(1, q1.pop_front());
      end
      if (rst_n[1]) begin
         if (stalled) begin
            check("b_rd_hold", 32'(rd[1]), 1);
            check("b_addr_hold", 32'(addr[1]), 32'(st_addr));
         end
         stalled = rd[1] && wt[1];
         st_addr = addr[1];
      end else begin
         stalled = 1'b0;
      end
      if (watch && rst_n[1] && !done[1])
         check("b_pass_hold", 32'(pass[1]), 1);
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n  = 2'b00;
      start  = 2'b00;
      stall  = '{0, 3};
      ts_bad = '{0, 0};
      id_m   = '{32'd0, 32'd0};
      repeat (3) @(negedge clk);
      check_rst(0);
      check_rst(1);

      // defaults, zero-wait; start while busy must be ignored
      d0 = dones[0];
      q0.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, EXP_TS, 4'd0, 4));
      rst_n[0] = 1'b1;
      @(negedge clk);
      check("a_c1_read", 32'(rd[0]), 1);
      check("a_c1_addr", 32'(addr[0]), 0);
      check("a_c1_busy", 32'(busy[0]), 1);
      @(negedge clk);
      check("a_c2_read", 32'(rd[0]), 1);
      check("a_c2_addr", 32'(addr[0]), 1);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_drain(0, 40);
      repeat (8) @(negedge clk);
      check("a_one_done", 32'(dones[0] - d0), 1);
      check("a_hold_busy", 32'(busy[0]), 0);

      // start in HOLD reruns the check
      q0.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, EXP_TS, 4'd0, -1));
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_drain(0, 40);

      // timestamp always wrong: retries exhausted
      rst_n[0] = 1'b0;
      ts_bad[0] = 1000;
      @(negedge clk);
      check_rst(0);
      q0.push_back(mk(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd3, 13));
      rst_n[0] = 1'b1;
      wait_drain(0, 60);
      check("a_ts_rounds", 32'(ts_rd[0]), 4);

      // timestamp wrong for two rounds, then correct
      rst_n[0] = 1'b0;
      ts_bad[0] = 2;
      @(negedge clk);
      d0 = dones[0];
      q0.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, EXP_TS, 4'd2, 10));
      rst_n[0] = 1'b1;
      wait_drain(0, 60);
      repeat (10) @(negedge clk);
      check("a_retry_one_done", 32'(dones[0] - d0), 1);

      // latency 2 with 3 stall cycles per read
      d1 = dones[1];
      q1.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, EXP_TS, 4'd0, 14));
      rst_n[1] = 1'b1;
      wait_drain(1, 60);

      // ID changes after first pass; periodic re-check must fail cleanly
      id_m[1] = 32'h5;
      q1.push_back(mk(1'b0, 1'b1, 1'b0, 32'h5, EXP_TS, 4'd3, -1));
      watch = 1'b1;
      wait_drain(1, 200);
      watch = 1'b0;
      check("b_two_dones", 32'(dones[1] - d1), 2);
      rst_n[1] = 1'b0;
      id_m[1] = 32'd0;
      @(negedge clk);
      check_rst(1);

      // start while busy, then reset dropped inside LAT_TS
      rst_n[1] = 1'b1;
      repeat (5) @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      repeat (5) @(negedge clk);
      check("b_lat_ts_busy", 32'(busy[1]), 1);
      check("b_lat_ts_read", 32'(rd[1]), 0);
      rst_n[1] = 1'b0;
      #1;
      check_rst(1);
      @(negedge clk);
      d1 = dones[1];
      q1.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, EXP_TS, 4'd0, 14));
      rst_n[1] = 1'b1;
      repeat (5) @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      wait_drain(1, 60);
      repeat (5) @(negedge clk);
      check("b_rerun_one_done", 32'(dones[1] - d1), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
